// File: rtl/debounce_pkg.sv
// Shared types and limits for the multi-key debouncer.
package debounce_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS   = 3'd1,
    P_LOCK  = 3'd2,
    HELD    = 3'd3,
    RELEASE = 3'd4,
    R_LOCK  = 3'd5
  } key_state_t;

  localparam int MIN_TOLERANCE_TICKS = 5;
  localparam int MIN_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_channel.sv
// One key channel: input synchronizer, debounce FSM with lock-out,
// hold timer for long press and auto-repeat. All outputs are registered.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int TOLERANCE_TICKS = 5,
  parameter int LONG_TICKS      = 1000,
  parameter int REPEAT_TICKS    = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic key,
  output logic press,
  output logic deprs,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int HOLD_W   = $clog2(LONG_TICKS + REPEAT_TICKS + 1);
  localparam int LOCK_W   = $clog2(TOLERANCE_TICKS);
  localparam int REP_W    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam int REP_LAST = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_in;
  key_state_t             state, state_next;
  logic [LOCK_W-1:0]      lock_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [REP_W-1:0]       rep_cnt;
  logic                   lock_done;
  logic                   holding;
  logic                   rep_armed;
  logic                   long_due;
  logic                   rep_due;
  logic                   key_d, press_d, deprs_d, long_d, rep_d;

  assign sync_in = sync_p[SYNC_STAGES-1];

  // Shift the raw key through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
  end

  // PRESS/RELEASE is one cycle, each lock state lasts TOLERANCE_TICKS-1 cycles,
  // so the level is held for at least TOLERANCE_TICKS cycles after an edge.
  assign lock_done = (lock_cnt == LOCK_W'(TOLERANCE_TICKS - 2));
  assign holding   = (state == P_LOCK) || (state == HELD);
  // Once the hold counter passes the long-press point the repeat timer runs.
  assign rep_armed = (hold_cnt >= HOLD_W'(LONG_TICKS));
  // Requiring sync_in=1 lets a release in the same cycle suppress the pulse.
  assign long_due  = holding && sync_in && (hold_cnt == HOLD_W'(LONG_TICKS - 1));
  assign rep_due   = (REPEAT_TICKS > 0) && holding && sync_in && rep_armed &&
                     (rep_cnt == REP_W'(REP_LAST));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; input is ignored while in a lock state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sync_in)   state_next = PRESS;
      PRESS:                  state_next = P_LOCK;
      P_LOCK:  if (lock_done) state_next = HELD;
      HELD:    if (!sync_in)  state_next = RELEASE;
      RELEASE:                state_next = R_LOCK;
      R_LOCK:  if (lock_done) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // FSM output decode; these values are registered one cycle later.
  always_comb begin
    key_d   = (state == PRESS) || (state == P_LOCK) || (state == HELD);
    press_d = (state == PRESS);
    deprs_d = (state == RELEASE);
    long_d  = long_due;
    rep_d   = rep_due;
  end

  // Lock-out counter, restarted on every accepted edge.
  always_ff @(posedge clk) begin
    if (rst)                                          lock_cnt <= '0;
    else if (state == PRESS || state == RELEASE)      lock_cnt <= '0;
    else if ((state == P_LOCK || state == R_LOCK) && !lock_done)
                                                      lock_cnt <= lock_cnt + 1'b1;
  end

  // Hold counter: cleared on press, counts while held, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                              hold_cnt <= '0;
    else if (state == PRESS)              hold_cnt <= '0;
    else if (holding && hold_cnt != '1)   hold_cnt <= hold_cnt + 1'b1;
  end

  // Repeat counter: reloads on every long/repeat pulse so periods never drift.
  always_ff @(posedge clk) begin
    if (rst)                        rep_cnt <= '0;
    else if (state == PRESS)        rep_cnt <= '0;
    else if (long_due || rep_due)   rep_cnt <= '0;
    else if (holding && rep_armed && rep_cnt != REP_W'(REP_LAST))
                                    rep_cnt <= rep_cnt + 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key          <= 1'b0;
      press        <= 1'b0;
      deprs        <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      key          <= key_d;
      press        <= press_d;
      deprs        <= deprs_d;
      long_pulse   <= long_d;
      repeat_pulse <= rep_d;
    end
  end

endmodule

// File: rtl/multi_key_debounce.sv
// N-key debouncer top: parameter checks, one debounce_channel per key,
// and an any-key indicator.
module multi_key_debounce
  import debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int TOLERANCE_TICKS = 5,
  parameter int LONG_TICKS      = 1000,
  parameter int REPEAT_TICKS    = 200
) (
  input  logic              Clk,
  input  logic              Srst,
  input  logic [N_KEYS-1:0] di_Key,
  output logic [N_KEYS-1:0] do_Key,
  output logic [N_KEYS-1:0] do_Press,
  output logic [N_KEYS-1:0] do_DePrs,
  output logic [N_KEYS-1:0] do_Long,
  output logic [N_KEYS-1:0] do_Repeat,
  output logic              do_AnyKey
);

  if (N_KEYS < 1) begin : g_bad_keys
    $error("N_KEYS must be >= 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end
  if (TOLERANCE_TICKS < MIN_TOLERANCE_TICKS) begin : g_bad_tol
    $error("TOLERANCE_TICKS must be >= %0d", MIN_TOLERANCE_TICKS);
  end
  if (LONG_TICKS <= TOLERANCE_TICKS) begin : g_bad_long
    $error("LONG_TICKS must exceed TOLERANCE_TICKS");
  end
  if (REPEAT_TICKS < 0) begin : g_bad_rep
    $error("REPEAT_TICKS must be >= 0");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .TOLERANCE_TICKS(TOLERANCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_ch (
      .clk         (Clk),
      .rst         (Srst),
      .raw         (di_Key[i]),
      .key         (do_Key[i]),
      .press       (do_Press[i]),
      .deprs       (do_DePrs[i]),
      .long_pulse  (do_Long[i]),
      .repeat_pulse(do_Repeat[i])
    );
  end

  assign do_AnyKey = |do_Key;

endmodule
